store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Circular FIFO holding speculative stores from the LSU execute stage (exlsu) until the ROB commits them; committed head entries drain to the memory bus one at a time.
- Proxies load reads to the bus and overlays bytes from buffered stores onto the returned load data (store-to-load forwarding).
- Sits between exlsu/issue and the bus arbiter; consumes commit_feedback_pack_t from the commit stage.

Parameters:
- STORE_BUFFER_SIZE, 16, entry count (power of two).
- Widths come from the shared config: ADDR_WIDTH 32, SIZE_WIDTH, BUS_DATA_WIDTH 32, REG_DATA_WIDTH 32, ROB_ID_WIDTH, COMMIT_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- issue_stbuf_read_addr  in  ADDR_WIDTH  load address
- issue_stbuf_read_size  in  SIZE_WIDTH  load size in bytes (1/2/4)
- issue_stbuf_rd  in  1  load request
- stbuf_exlsu_bus_data  out  BUS_DATA_WIDTH  merged load data
- stbuf_exlsu_bus_data_feedback  out  BUS_DATA_WIDTH  forwarding byte mask
- stbuf_exlsu_bus_ready  out  1  load data valid
- exlsu_stbuf_rob_id  in  ROB_ID_WIDTH  store ROB id
- exlsu_stbuf_write_addr  in  ADDR_WIDTH  store address
- exlsu_stbuf_write_size  in  SIZE_WIDTH  store size
- exlsu_stbuf_write_data  in  BUS_DATA_WIDTH  store data
- exlsu_stbuf_push  in  1  enqueue store
- stbuf_exlsu_full  out  1  buffer full
- stbuf_all_empty  out  1  no valid entries
- stbuf_bus_read_addr / stbuf_bus_read_size  out  ADDR_WIDTH / SIZE_WIDTH  bus read request fields
- stbuf_bus_read_req  out  1  bus read request
- stbuf_bus_write_addr / stbuf_bus_write_size  out  ADDR_WIDTH / SIZE_WIDTH  bus write request fields
- stbuf_bus_data  out  REG_DATA_WIDTH  bus write data
- stbuf_bus_write_req  out  1  bus write request
- bus_stbuf_data  in  REG_DATA_WIDTH  bus read data
- bus_stbuf_read_ack / bus_stbuf_write_ack  in  1  bus handshakes
- commit_feedback_pack  in  commit_feedback_pack_t  commit/flush info

Behaviour:
- State: rptr, wptr (index, log2 depth bits), count. Per entry: committed, rob_id, addr, size, data.
- Reset: pointers, count and all flags are 0; all req outputs are 0; full=0; all_empty=1; ready=0.
- Push: exlsu_stbuf_push && !full writes the entry at wptr with committed=0, then wptr++ (wraps).
- Push while full is ignored.
- full = (count == STORE_BUFFER_SIZE); all_empty = (count == 0).
- Commit: when enable=1, every valid entry whose rob_id equals committed_rob_id[i] with committed_rob_id_valid[i]=1 gets committed=1.
- Flush: when enable && flush, all uncommitted entries are discarded; wptr is rolled back to the first uncommitted entry and count is recomputed.
- A push in the same cycle as a flush is dropped. Committed entries survive the flush.
- Drain: stbuf_bus_write_req = (count != 0) && entry[rptr].committed, combinational.
- Write fields come from entry[rptr]; stbuf_bus_data is zero-extended above size bytes.
- bus_stbuf_write_ack pops the head: rptr++, count--. The ack arrives no earlier than the cycle after req. Req holds until ack.
- Pop, push and commit may coincide; count is adjusted by both push and pop.
- Load read: issue_stbuf_rd registers addr/size. The next cycle stbuf_bus_read_req=1 with those fields, held until bus_stbuf_read_ack.
- A new issue_stbuf_rd is accepted only when no read is pending or in the ack cycle.
- stbuf_exlsu_bus_ready = bus_stbuf_read_ack, combinational. On that cycle each byte k < size at addr+k is taken from the youngest valid entry (committed or not) covering that byte; otherwise from bus_stbuf_data byte k.
- feedback byte k = 0xFF if forwarded, else 0x00. Bytes ≥ size are 0.
- Forwarding scans entries in the ack cycle, including an entry being popped that cycle; a push in the same cycle is not seen.

Decomposition:
- Shared package/config: width macros, STORE_BUFFER_SIZE, commit_feedback_pack_t (enable, next_handle_rob_id[_valid], has_exception, exception_pc, flush, committed_rob_id[COMMIT_WIDTH], committed_rob_id_valid[COMMIT_WIDTH], jump_enable, jump, next_pc).
- One sub-module, store_buffer_forward: combinational byte-wise youngest-match merge.

Test Plan:
- Reset, then push 16 stores (rob 0..15): full=1 after the 16th; a 17th push is ignored and wptr stays 0.
- Push sw 0x100=0xDEADBEEF rob 3, then commit rob 3: write_req=1, addr 0x100, size 4, data 0xDEADBEEF. Ack next cycle: rptr=1, all_empty=1.
- Push rob 1, 2; commit rob 1; flush: entry 1 remains and drains, wptr=1, rob 2 is gone.
- Buffered sb 0x201=0xAA; load lw 0x200; bus returns 0x11223344 on ack: data=0x1122AA44, feedback=0x0000FF00, ready same cycle.
- Two stores to 0x300 (0x11 then 0x22, size 1), then lb 0x300: data byte=0x22 (youngest wins).
- Pointer wrap: 20 push/commit/ack cycles: rptr/wptr wrap 15→0; empty/full are correct throughout.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared widths, commit feedback bundle and store buffer entry types.
package store_buffer_pkg;

    localparam int ADDR_WIDTH        = 32;
    localparam int SIZE_WIDTH        = 3;
    localparam int BUS_DATA_WIDTH    = 32;
    localparam int REG_DATA_WIDTH    = 32;
    localparam int ROB_ID_WIDTH      = 5;
    localparam int COMMIT_WIDTH      = 2;

    localparam int STORE_BUFFER_SIZE = 16;
    localparam int SB_IDX_WIDTH      = $clog2(STORE_BUFFER_SIZE);
    localparam int SB_CNT_WIDTH      = SB_IDX_WIDTH + 1;
    localparam int BUS_BYTES         = BUS_DATA_WIDTH / 8;

    typedef struct packed {
        logic                                       enable;
        logic [COMMIT_WIDTH-1:0][ROB_ID_WIDTH-1:0]  next_handle_rob_id;
        logic [COMMIT_WIDTH-1:0]                    next_handle_rob_id_valid;
        logic                                       has_exception;
        logic [ADDR_WIDTH-1:0]                      exception_pc;
        logic                                       flush;
        logic [COMMIT_WIDTH-1:0][ROB_ID_WIDTH-1:0]  committed_rob_id;
        logic [COMMIT_WIDTH-1:0]                    committed_rob_id_valid;
        logic                                       jump_enable;
        logic                                       jump;
        logic [ADDR_WIDTH-1:0]                      next_pc;
    } commit_feedback_pack_t;

    // Fields the forwarding network needs from a buffered store.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0]     addr;
        logic [SIZE_WIDTH-1:0]     size;
        logic [BUS_DATA_WIDTH-1:0] data;
    } sb_store_t;

    typedef struct packed {
        logic                    committed;
        logic [ROB_ID_WIDTH-1:0] rob_id;
        sb_store_t               st;
    } sb_entry_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_PEND = 1'b1
    } rd_state_e;

    // Byte-enable style mask covering the low 'size' bytes of a bus word.
    function automatic logic [BUS_DATA_WIDTH-1:0] size_mask(input logic [SIZE_WIDTH-1:0] size);
        logic [BUS_DATA_WIDTH-1:0] m;
        m = '0;
        for (int k = 0; k < BUS_BYTES; k++) begin
            if (k < int'(size)) begin
                m[k*8 +: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/store_buffer_forward.sv
// Store-to-load forwarding: per load byte, take the youngest valid store
// covering that byte address, otherwise the byte returned by the bus.
module store_buffer_forward
    import store_buffer_pkg::*;
(
    input  sb_store_t [STORE_BUFFER_SIZE-1:0] stores,
    input  logic [STORE_BUFFER_SIZE-1:0]      store_valid,
    input  logic [SB_IDX_WIDTH-1:0]           rptr,
    input  logic [ADDR_WIDTH-1:0]             read_addr,
    input  logic [SIZE_WIDTH-1:0]             read_size,
    input  logic [REG_DATA_WIDTH-1:0]         bus_data,
    output logic [BUS_DATA_WIDTH-1:0]         merged_data,
    output logic [BUS_DATA_WIDTH-1:0]         fwd_mask
);

    logic [SB_IDX_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0]   byte_addr;
    logic [ADDR_WIDTH-1:0]   off;

    // Walk from oldest (rptr) to youngest so later matches overwrite earlier ones.
    always_comb begin
        merged_data = '0;
        fwd_mask    = '0;
        idx         = '0;
        byte_addr   = '0;
        off         = '0;
        for (int k = 0; k < BUS_BYTES; k++) begin
            if (k < int'(read_size)) begin
                byte_addr           = read_addr + ADDR_WIDTH'(k);
                merged_data[k*8 +: 8] = bus_data[k*8 +: 8];
                for (int j = 0; j < STORE_BUFFER_SIZE; j++) begin
                    idx = rptr + SB_IDX_WIDTH'(j);
                    off = byte_addr - stores[idx].addr;
                    if (store_valid[idx] && (off < ADDR_WIDTH'(stores[idx].size))) begin
                        merged_data[k*8 +: 8] = stores[idx].data[{off[1:0], 3'b000} +: 8];
                        fwd_mask[k*8 +: 8]    = 8'hFF;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer: holds speculative stores until commit, drains the
// committed head to the bus, and proxies loads with store-to-load forwarding.
//
// Handshakes: stbuf_bus_write_req and stbuf_bus_read_req behave as valid;
// once raised they hold with stable fields until the matching ack, and a
// transfer completes in the cycle where req and ack are both high. A push is
// taken only when exlsu_stbuf_push is high and stbuf_exlsu_full is low.
module store_buffer
    import store_buffer_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_WIDTH-1:0]         issue_stbuf_read_addr,
    input  logic [SIZE_WIDTH-1:0]         issue_stbuf_read_size,
    input  logic                          issue_stbuf_rd,
    output logic [BUS_DATA_WIDTH-1:0]     stbuf_exlsu_bus_data,
    output logic [BUS_DATA_WIDTH-1:0]     stbuf_exlsu_bus_data_feedback,
    output logic                          stbuf_exlsu_bus_ready,
    input  logic [ROB_ID_WIDTH-1:0]       exlsu_stbuf_rob_id,
    input  logic [ADDR_WIDTH-1:0]         exlsu_stbuf_write_addr,
    input  logic [SIZE_WIDTH-1:0]         exlsu_stbuf_write_size,
    input  logic [BUS_DATA_WIDTH-1:0]     exlsu_stbuf_write_data,
    input  logic                          exlsu_stbuf_push,
    output logic                          stbuf_exlsu_full,
    output logic                          stbuf_all_empty,
    output logic [ADDR_WIDTH-1:0]         stbuf_bus_read_addr,
    output logic [SIZE_WIDTH-1:0]         stbuf_bus_read_size,
    output logic                          stbuf_bus_read_req,
    output logic [ADDR_WIDTH-1:0]         stbuf_bus_write_addr,
    output logic [SIZE_WIDTH-1:0]         stbuf_bus_write_size,
    output logic [REG_DATA_WIDTH-1:0]     stbuf_bus_data,
    output logic                          stbuf_bus_write_req,
    input  logic [REG_DATA_WIDTH-1:0]     bus_stbuf_data,
    input  logic                          bus_stbuf_read_ack,
    input  logic                          bus_stbuf_write_ack,
    input  commit_feedback_pack_t         commit_feedback_pack,
    output logic [SB_IDX_WIDTH-1:0]       dbg_rptr,
    output logic [SB_IDX_WIDTH-1:0]       dbg_wptr,
    output logic [SB_CNT_WIDTH-1:0]       dbg_count,
    output rd_state_e                     dbg_rd_state
);

    sb_entry_t [STORE_BUFFER_SIZE-1:0] entries;
    sb_store_t [STORE_BUFFER_SIZE-1:0] store_view;
    logic [SB_IDX_WIDTH-1:0]           rptr, wptr;
    logic [SB_CNT_WIDTH-1:0]           count;
    logic [STORE_BUFFER_SIZE-1:0]      entry_valid;
    logic [STORE_BUFFER_SIZE-1:0]      commit_hit;
    logic [SB_CNT_WIDTH-1:0]           keep_len;
    logic                              keep_found;
    logic [SB_IDX_WIDTH-1:0]           scan_idx;
    logic [SB_IDX_WIDTH-1:0]           age;
    sb_entry_t                         head;
    sb_entry_t                         new_entry;
    logic                              do_flush, push_ok, pop;

    rd_state_e                         rd_state, rd_state_next;
    logic                              rd_accept;
    logic [ADDR_WIDTH-1:0]             rd_addr_q;
    logic [SIZE_WIDTH-1:0]             rd_size_q;

    logic                              unused_cf;
    assign unused_cf = ^{commit_feedback_pack.next_handle_rob_id,
                         commit_feedback_pack.next_handle_rob_id_valid,
                         commit_feedback_pack.has_exception,
                         commit_feedback_pack.exception_pc,
                         commit_feedback_pack.jump_enable,
                         commit_feedback_pack.jump,
                         commit_feedback_pack.next_pc};

    assign stbuf_exlsu_full    = (count == SB_CNT_WIDTH'(STORE_BUFFER_SIZE));
    assign stbuf_all_empty     = (count == '0);
    assign head                = entries[rptr];
    assign stbuf_bus_write_req = !stbuf_all_empty && head.committed;
    assign pop                 = stbuf_bus_write_req && bus_stbuf_write_ack;
    assign do_flush            = commit_feedback_pack.enable && commit_feedback_pack.flush;
    assign push_ok             = exlsu_stbuf_push && !stbuf_exlsu_full && !do_flush;

    assign stbuf_bus_write_addr = head.st.addr;
    assign stbuf_bus_write_size = head.st.size;
    assign stbuf_bus_data       = head.st.data & size_mask(head.st.size);

    assign dbg_rptr     = rptr;
    assign dbg_wptr     = wptr;
    assign dbg_count    = count;
    assign dbg_rd_state = rd_state;

    // Entry i is live when its age relative to the head is below count.
    always_comb begin
        entry_valid = '0;
        age         = '0;
        for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
            age            = SB_IDX_WIDTH'(i) - rptr;
            entry_valid[i] = ({1'b0, age} < count);
            store_view[i]  = entries[i].st;
        end
    end

    // Mark live entries whose rob id matches any valid commit slot.
    always_comb begin
        commit_hit = '0;
        for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
            for (int c = 0; c < COMMIT_WIDTH; c++) begin
                if (commit_feedback_pack.enable && commit_feedback_pack.committed_rob_id_valid[c] &&
                    entry_valid[i] && (entries[i].rob_id == commit_feedback_pack.committed_rob_id[c])) begin
                    commit_hit[i] = 1'b1;
                end
            end
        end
    end

    // On flush the buffer keeps entries up to the first uncommitted one.
    always_comb begin
        keep_len   = count;
        keep_found = 1'b0;
        scan_idx   = '0;
        for (int j = 0; j < STORE_BUFFER_SIZE; j++) begin
            scan_idx = rptr + SB_IDX_WIDTH'(j);
            if (!keep_found && (SB_CNT_WIDTH'(j) < count) &&
                !(entries[scan_idx].committed || commit_hit[scan_idx])) begin
                keep_len   = SB_CNT_WIDTH'(j);
                keep_found = 1'b1;
            end
        end
    end

    // Incoming store, always enqueued uncommitted.
    always_comb begin
        new_entry           = '0;
        new_entry.committed = 1'b0;
        new_entry.rob_id    = exlsu_stbuf_rob_id;
        new_entry.st.addr   = exlsu_stbuf_write_addr;
        new_entry.st.size   = exlsu_stbuf_write_size;
        new_entry.st.data   = exlsu_stbuf_write_data;
    end

    // Pointer and occupancy bookkeeping; flush rolls wptr back behind the kept prefix.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (do_flush) begin
                wptr  <= rptr + keep_len[SB_IDX_WIDTH-1:0];
                count <= keep_len - SB_CNT_WIDTH'(pop);
            end else begin
                if (push_ok) begin
                    wptr <= wptr + 1'b1;
                end
                count <= count + SB_CNT_WIDTH'(push_ok) - SB_CNT_WIDTH'(pop);
            end
        end
    end

    // Entry storage: write the pushed store, or set committed on a matching commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entries <= '0;
        end else begin
            for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
                if (push_ok && (wptr == SB_IDX_WIDTH'(i))) begin
                    entries[i] <= new_entry;
                end else if (commit_hit[i]) begin
                    entries[i].committed <= 1'b1;
                end
            end
        end
    end

    // Load proxy state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state  <= RD_IDLE;
            rd_addr_q <= '0;
            rd_size_q <= '0;
        end else begin
            rd_state <= rd_state_next;
            if (rd_accept) begin
                rd_addr_q <= issue_stbuf_read_addr;
                rd_size_q <= issue_stbuf_read_size;
            end
        end
    end

    // Load proxy next state: a new load is taken when idle or in the ack cycle.
    always_comb begin
        rd_state_next = rd_state;
        rd_accept     = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (issue_stbuf_rd) begin
                    rd_accept     = 1'b1;
                    rd_state_next = RD_PEND;
                end
            end
            RD_PEND: begin
                if (bus_stbuf_read_ack) begin
                    rd_accept     = issue_stbuf_rd;
                    rd_state_next = issue_stbuf_rd ? RD_PEND : RD_IDLE;
                end
            end
            default: rd_state_next = RD_IDLE;
        endcase
    end

    assign stbuf_bus_read_req    = (rd_state == RD_PEND);
    assign stbuf_bus_read_addr   = rd_addr_q;
    assign stbuf_bus_read_size   = rd_size_q;
    assign stbuf_exlsu_bus_ready = bus_stbuf_read_ack;

    store_buffer_forward u_forward (
        .stores      (store_view),
        .store_valid (entry_valid),
        .rptr        (rptr),
        .read_addr   (rd_addr_q),
        .read_size   (rd_size_q),
        .bus_data    (bus_stbuf_data),
        .merged_data (stbuf_exlsu_bus_data),
        .fwd_mask    (stbuf_exlsu_bus_data_feedback)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus randomized traffic against
// a queue-based reference model of the buffer and the load proxy.
`timescale 1ns/1ps
module tb_store_buffer;
    import store_buffer_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [ADDR_WIDTH-1:0]     issue_stbuf_read_addr;
    logic [SIZE_WIDTH-1:0]     issue_stbuf_read_size;
    logic                      issue_stbuf_rd;
    logic [BUS_DATA_WIDTH-1:0] stbuf_exlsu_bus_data;
    logic [BUS_DATA_WIDTH-1:0] stbuf_exlsu_bus_data_feedback;
    logic                      stbuf_exlsu_bus_ready;
    logic [ROB_ID_WIDTH-1:0]   exlsu_stbuf_rob_id;
    logic [ADDR_WIDTH-1:0]     exlsu_stbuf_write_addr;
    logic [SIZE_WIDTH-1:0]     exlsu_stbuf_write_size;
    logic [BUS_DATA_WIDTH-1:0] exlsu_stbuf_write_data;
    logic                      exlsu_stbuf_push;
    logic                      stbuf_exlsu_full;
    logic                      stbuf_all_empty;
    logic [ADDR_WIDTH-1:0]     stbuf_bus_read_addr;
    logic [SIZE_WIDTH-1:0]     stbuf_bus_read_size;
    logic                      stbuf_bus_read_req;
    logic [ADDR_WIDTH-1:0]     stbuf_bus_write_addr;
    logic [SIZE_WIDTH-1:0]     stbuf_bus_write_size;
    logic [REG_DATA_WIDTH-1:0] stbuf_bus_data;
    logic                      stbuf_bus_write_req;
    logic [REG_DATA_WIDTH-1:0] bus_stbuf_data;
    logic                      bus_stbuf_read_ack;
    logic                      bus_stbuf_write_ack;
    commit_feedback_pack_t     cf;
    logic [SB_IDX_WIDTH-1:0]   dbg_rptr, dbg_wptr;
    logic [SB_CNT_WIDTH-1:0]   dbg_count;
    rd_state_e                 dbg_rd_state;

    store_buffer dut (
        .clk                           (clk),
        .rst                           (rst),
        .issue_stbuf_read_addr         (issue_stbuf_read_addr),
        .issue_stbuf_read_size         (issue_stbuf_read_size),
        .issue_stbuf_rd                (issue_stbuf_rd),
        .stbuf_exlsu_bus_data          (stbuf_exlsu_bus_data),
        .stbuf_exlsu_bus_data_feedback (stbuf_exlsu_bus_data_feedback),
        .stbuf_exlsu_bus_ready         (stbuf_exlsu_bus_ready),
        .exlsu_stbuf_rob_id            (exlsu_stbuf_rob_id),
        .exlsu_stbuf_write_addr        (exlsu_stbuf_write_addr),
        .exlsu_stbuf_write_size        (exlsu_stbuf_write_size),
        .exlsu_stbuf_write_data        (exlsu_stbuf_write_data),
        .exlsu_stbuf_push              (exlsu_stbuf_push),
        .stbuf_exlsu_full              (stbuf_exlsu_full),
        .stbuf_all_empty               (stbuf_all_empty),
        .stbuf_bus_read_addr           (stbuf_bus_read_addr),
        .stbuf_bus_read_size           (stbuf_bus_read_size),
        .stbuf_bus_read_req            (stbuf_bus_read_req),
        .stbuf_bus_write_addr          (stbuf_bus_write_addr),
        .stbuf_bus_write_size          (stbuf_bus_write_size),
        .stbuf_bus_data                (stbuf_bus_data),
        .stbuf_bus_write_req           (stbuf_bus_write_req),
        .bus_stbuf_data                (bus_stbuf_data),
        .bus_stbuf_read_ack            (bus_stbuf_read_ack),
        .bus_stbuf_write_ack           (bus_stbuf_write_ack),
        .commit_feedback_pack          (cf),
        .dbg_rptr                      (dbg_rptr),
        .dbg_wptr                      (dbg_wptr),
        .dbg_count                     (dbg_count),
        .dbg_rd_state                  (dbg_rd_state)
    );

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          committed;
        int          rob;
        logic [31:0] addr;
        int          size;
        logic [31:0] data;
    } m_entry_t;

    m_entry_t    m_q[$];        // live stores, oldest first
    logic [31:0] exp_q[$];      // expected drain data, in commit order
    int          m_rp;
    bit          m_pend;
    logic [31:0] m_rd_addr;
    int          m_rd_size;
    bit          m_wreq_prev;
    int          next_rob;

    function automatic logic [31:0] m_mask(input int sz);
        return (sz >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
    endfunction

    function automatic bit m_wreq();
        return (m_q.size() != 0) && m_q[0].committed;
    endfunction

    // Byte k of the load comes from the youngest live store covering addr+k.
    function automatic void m_load(input logic [31:0] bus, output logic [31:0] d, output logic [31:0] fb);
        logic [31:0] b, sh;
        logic [7:0]  byt;
        d  = '0;
        fb = '0;
        for (int k = 0; k < m_rd_size; k++) begin
            b   = m_rd_addr + k;
            sh  = bus >> (8 * k);
            byt = sh[7:0];
            for (int e = m_q.size() - 1; e >= 0; e--) begin
                if (b >= m_q[e].addr && b < m_q[e].addr + m_q[e].size) begin
                    sh  = m_q[e].data >> (8 * (b - m_q[e].addr));
                    byt = sh[7:0];
                    fb[8*k +: 8] = 8'hFF;
                    break;
                end
            end
            d[8*k +: 8] = byt;
        end
    endfunction

    // Apply one clock of inputs to the model (pre-edge state in, post-edge state out).
    function automatic void model_step();
        bit       wreq, pop, flush, accept;
        int       pre_size;
        m_entry_t kept[$];
        m_entry_t ne;
        wreq     = m_wreq();
        pre_size = m_q.size();
        pop      = bus_stbuf_write_ack && wreq;
        flush    = cf.enable && cf.flush;
        if (cf.enable) begin
            for (int e = 0; e < m_q.size(); e++) begin
                for (int c = 0; c < COMMIT_WIDTH; c++) begin
                    if (cf.committed_rob_id_valid[c] && cf.committed_rob_id[c] == 5'(m_q[e].rob) && !m_q[e].committed) begin
                        m_q[e].committed = 1'b1;
                        exp_q.push_back(m_q[e].data & m_mask(m_q[e].size));
                    end
                end
            end
        end
        if (flush) begin
            foreach (m_q[e]) if (m_q[e].committed) kept.push_back(m_q[e]);
            m_q = kept;
            if (m_q.size() != 0) next_rob = (m_q[m_q.size()-1].rob + 1) % 32;
        end
        if (pop) begin
            void'(m_q.pop_front());
            m_rp = (m_rp + 1) % STORE_BUFFER_SIZE;
        end
        if (exlsu_stbuf_push && !flush && pre_size < STORE_BUFFER_SIZE) begin
            ne.committed = 1'b0;
            ne.rob       = int'(exlsu_stbuf_rob_id);
            ne.addr      = exlsu_stbuf_write_addr;
            ne.size      = int'(exlsu_stbuf_write_size);
            ne.data      = exlsu_stbuf_write_data;
            m_q.push_back(ne);
            next_rob = (ne.rob + 1) % 32;
        end
        accept = issue_stbuf_rd && (!m_pend || bus_stbuf_read_ack);
        if (accept) begin
            m_pend    = 1'b1;
            m_rd_addr = issue_stbuf_read_addr;
            m_rd_size = int'(issue_stbuf_read_size);
        end else if (bus_stbuf_read_ack) begin
            m_pend = 1'b0;
        end
        m_wreq_prev = wreq && !pop;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        issue_stbuf_read_addr  = '0;
        issue_stbuf_read_size  = '0;
        issue_stbuf_rd         = 1'b0;
        exlsu_stbuf_rob_id     = '0;
        exlsu_stbuf_write_addr = '0;
        exlsu_stbuf_write_size = '0;
        exlsu_stbuf_write_data = '0;
        exlsu_stbuf_push       = 1'b0;
        bus_stbuf_data         = '0;
        bus_stbuf_read_ack     = 1'b0;
        bus_stbuf_write_ack    = 1'b0;
        cf                     = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        m_q.delete();
        exp_q.delete();
        m_rp        = 0;
        m_pend      = 1'b0;
        m_wreq_prev = 1'b0;
        next_rob    = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_full",      stbuf_exlsu_full, 0);
        check_eq("rst_empty",     stbuf_all_empty, 1);
        check_eq("rst_write_req", stbuf_bus_write_req, 0);
        check_eq("rst_read_req",  stbuf_bus_read_req, 0);
        check_eq("rst_ready",     stbuf_exlsu_bus_ready, 0);
        check_eq("rst_rptr",      dbg_rptr, 0);
        check_eq("rst_wptr",      dbg_wptr, 0);
        rst = 1'b1;
    endtask

    task automatic set_push(input int rob, input logic [31:0] addr, input int size, input logic [31:0] data);
        exlsu_stbuf_push       = 1'b1;
        exlsu_stbuf_rob_id     = ROB_ID_WIDTH'(rob);
        exlsu_stbuf_write_addr = addr;
        exlsu_stbuf_write_size = SIZE_WIDTH'(size);
        exlsu_stbuf_write_data = data;
    endtask

    task automatic set_commit(input int rob);
        cf.enable                    = 1'b1;
        cf.committed_rob_id[0]       = ROB_ID_WIDTH'(rob);
        cf.committed_rob_id_valid[0] = 1'b1;
    endtask

    task automatic set_load(input logic [31:0] addr, input int size);
        issue_stbuf_rd        = 1'b1;
        issue_stbuf_read_addr = addr;
        issue_stbuf_read_size = SIZE_WIDTH'(size);
    endtask

    // Mid-cycle: compare combinational outputs with the model, then advance the model.
    task automatic settle();
        logic [31:0] ed, ef;
        bit wreq;
        #1;
        wreq = m_wreq();
        check_eq("full",      stbuf_exlsu_full, 32'(m_q.size() == STORE_BUFFER_SIZE));
        check_eq("all_empty", stbuf_all_empty,  32'(m_q.size() == 0));
        check_eq("write_req", stbuf_bus_write_req, 32'(wreq));
        if (wreq) begin
            check_eq("write_addr", stbuf_bus_write_addr, m_q[0].addr);
            check_eq("write_size", 32'(stbuf_bus_write_size), m_q[0].size);
            check_eq("write_data", stbuf_bus_data, m_q[0].data & m_mask(m_q[0].size));
        end
        check_eq("read_req", stbuf_bus_read_req, 32'(m_pend));
        check_eq("rd_state", 32'(dbg_rd_state == RD_PEND), 32'(m_pend));
        if (m_pend) begin
            check_eq("read_addr", stbuf_bus_read_addr, m_rd_addr);
            check_eq("read_size", 32'(stbuf_bus_read_size), m_rd_size);
        end
        check_eq("ready", stbuf_exlsu_bus_ready, 32'(bus_stbuf_read_ack));
        if (bus_stbuf_read_ack && m_pend) begin
            m_load(bus_stbuf_data, ed, ef);
            check_eq("load_data", stbuf_exlsu_bus_data & m_mask(m_rd_size), ed);
            check_eq("load_feedback", stbuf_exlsu_bus_data_feedback, ef);
        end
        if (bus_stbuf_write_ack && wreq) begin
            check_eq("drain_q_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check_eq("drain_data", stbuf_bus_data, exp_q.pop_front());
        end
        model_step();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        check_eq("rptr",  dbg_rptr,  m_rp);
        check_eq("wptr",  dbg_wptr,  (m_rp + m_q.size()) % STORE_BUFFER_SIZE);
        check_eq("count", dbg_count, m_q.size());
        clear_inputs();
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        clear_inputs();

        // Fill to 16, then a 17th push is dropped.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_push(i, 32'h1000 + 32'(4 * i), 4, $urandom);
            step();
        end
        check_eq("full_after_16", stbuf_exlsu_full, 1);
        set_push(16, 32'h2000, 4, 32'h12345678);
        step();
        check_eq("wptr_after_17th", dbg_wptr, 0);
        check_eq("count_after_17th", dbg_count, 16);

        // Single store, commit, drain.
        do_reset();
        set_push(3, 32'h100, 4, 32'hDEADBEEF);
        step();
        set_commit(3);
        step();
        settle();
        check_eq("sw_req",  stbuf_bus_write_req, 1);
        check_eq("sw_addr", stbuf_bus_write_addr, 32'h100);
        check_eq("sw_size", 32'(stbuf_bus_write_size), 4);
        check_eq("sw_data", stbuf_bus_data, 32'hDEADBEEF);
        advance();
        bus_stbuf_write_ack = 1'b1;
        step();
        check_eq("sw_rptr_after_ack", dbg_rptr, 1);
        check_eq("sw_empty_after_ack", stbuf_all_empty, 1);

        // Flush keeps the committed entry only.
        do_reset();
        set_push(1, 32'h400, 4, 32'h55667788);
        step();
        set_push(2, 32'h404, 4, 32'h99AABBCC);
        step();
        set_commit(1);
        step();
        cf.enable = 1'b1;
        cf.flush  = 1'b1;
        set_push(5, 32'h408, 4, 32'h0BADF00D);
        step();
        check_eq("flush_wptr",  dbg_wptr, 1);
        check_eq("flush_count", dbg_count, 1);
        step();
        bus_stbuf_write_ack = 1'b1;
        settle();
        check_eq("flush_drain_addr", stbuf_bus_write_addr, 32'h400);
        advance();
        check_eq("flush_empty", stbuf_all_empty, 1);

        // Forward a buffered byte into a word load.
        do_reset();
        set_push(0, 32'h201, 1, 32'h000000AA);
        step();
        set_load(32'h200, 4);
        step();
        bus_stbuf_read_ack = 1'b1;
        bus_stbuf_data     = 32'h11223344;
        settle();
        check_eq("fwd_ready", stbuf_exlsu_bus_ready, 1);
        check_eq("fwd_data",  stbuf_exlsu_bus_data, 32'h1122AA44);
        check_eq("fwd_mask",  stbuf_exlsu_bus_data_feedback, 32'h0000FF00);
        advance();

        // Youngest store wins.
        do_reset();
        set_push(0, 32'h300, 1, 32'h00000011);
        step();
        set_push(1, 32'h300, 1, 32'h00000022);
        step();
        set_load(32'h300, 1);
        step();
        bus_stbuf_read_ack = 1'b1;
        bus_stbuf_data     = 32'h99887766;
        settle();
        check_eq("youngest_byte", 32'(stbuf_exlsu_bus_data[7:0]), 32'h22);
        check_eq("youngest_mask", stbuf_exlsu_bus_data_feedback, 32'h000000FF);
        advance();

        // Pointer wrap over 20 push/commit/ack rounds.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_push(i % 32, 32'h500 + 32'(4 * i), 4, $urandom);
            step();
            set_commit(i % 32);
            step();
            step();
            bus_stbuf_write_ack = 1'b1;
            step();
        end
        check_eq("wrap_rptr", dbg_rptr, 4);
        check_eq("wrap_wptr", dbg_wptr, 4);

        // Randomized traffic.
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            int sz, first_unc, nc, r;
            if ($urandom_range(1, 0) == 1) begin
                r  = $urandom_range(2, 0);
                sz = (r == 0) ? 1 : (r == 1) ? 2 : 4;
                set_push(next_rob, 32'h200 + (32'($urandom_range(15, 0)) & ~32'(sz - 1)), sz, $urandom);
            end
            if ($urandom_range(9, 0) < 3) begin
                r  = $urandom_range(2, 0);
                sz = (r == 0) ? 1 : (r == 1) ? 2 : 4;
                set_load(32'h200 + (32'($urandom_range(15, 0)) & ~32'(sz - 1)), sz);
            end
            if (m_pend && $urandom_range(1, 0) == 1) begin
                bus_stbuf_read_ack = 1'b1;
                bus_stbuf_data     = $urandom;
            end
            if (m_wreq() && m_wreq_prev && $urandom_range(1, 0) == 1) begin
                bus_stbuf_write_ack = 1'b1;
            end
            first_unc = -1;
            foreach (m_q[e]) if (first_unc < 0 && !m_q[e].committed) first_unc = e;
            r = $urandom_range(99, 0);
            if (r < 30 && first_unc >= 0) begin
                nc = $urandom_range(2, 1);
                cf.enable = 1'b1;
                for (int c = 0; c < nc; c++) begin
                    if (first_unc + c < m_q.size()) begin
                        cf.committed_rob_id[c]       = ROB_ID_WIDTH'(m_q[first_unc + c].rob);
                        cf.committed_rob_id_valid[c] = 1'b1;
                    end
                end
            end else if (r < 34) begin
                cf.enable = 1'b1;
                cf.flush  = 1'b1;
            end else if (r < 40 && first_unc >= 0) begin
                // Valid slots without enable must not commit anything.
                cf.committed_rob_id[0]       = ROB_ID_WIDTH'(m_q[first_unc].rob);
                cf.committed_rob_id_valid[0] = 1'b1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
